// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the generic pipeline stage register:
//   - per-stage control/data vector layouts (packed structs) and their widths
//   - stage occupancy state enum used by pipe_stage_reg
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Decoded control vector carried from operand fetch onwards.
  typedef struct packed {
    logic        is_wb;
    logic        is_ld;
    logic        is_st;
    logic        is_beq;
    logic        is_bgt;
    logic        is_ubranch;
    logic        is_ret;
    logic        is_call;
    logic [11:0] alu_sig;
    logic [3:0]  rd;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_of_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] immx;
    logic [31:0] op1;
    logic [31:0] op2;
  } of_alu_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] op2;
    logic [31:0] inst;
  } alu_ma_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] ld_result;
    logic [31:0] inst;
  } ma_rw_data_t;

  // Fetch has no decoded control yet; one spare bit keeps the vector non-empty.
  localparam int unsigned IF_OF_CTRL_W  = 1;
  localparam int unsigned IF_OF_DATA_W  = $bits(if_of_data_t);
  localparam int unsigned OF_ALU_CTRL_W = $bits(ctrl_t);
  localparam int unsigned OF_ALU_DATA_W = $bits(of_alu_data_t);
  localparam int unsigned ALU_MA_CTRL_W = $bits(ctrl_t);
  localparam int unsigned ALU_MA_DATA_W = $bits(alu_ma_data_t);
  localparam int unsigned MA_RW_CTRL_W  = $bits(ctrl_t);
  localparam int unsigned MA_RW_DATA_W  = $bits(ma_rw_data_t);

  // Number of entries held by the stage; SKID only exists with the skid entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_skid_entry.sv
// -----------------------------------------------------------------------------
// pipe_skid_entry
//   One valid + control + data register with clear and load. Used both as the
//   main (output) entry and as the skid entry of pipe_stage_reg.
//   Clear has priority over load. Control is always zeroed on clear; data is
//   zeroed only when ZERO_DATA is set, otherwise it is held to save toggling.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clr_i            invalidate the entry (flush / bubble)
//   load_i           capture ctrl_i/data_i and mark the entry valid
//   ctrl_i, data_i   payload to capture
//   valid_o          entry holds a valid payload
//   ctrl_o, data_o   registered payload
// -----------------------------------------------------------------------------
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W    = 24,
  parameter int unsigned DATA_W    = 160,
  parameter bit          ZERO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: the payload is reset too (not just valid) because downstream stages
  // decode ctrl/data directly and must see all-zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for every register so all state
      // updates see pre-edge values, independent of statement order.
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (ZERO_DATA) data_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule : pipe_skid_entry

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic valid/ready pipeline stage register carrying a control vector and a
//   data vector with one cycle of latency. Flush (branch taken) empties the
//   stage and has priority over stall, accept and pop. Stall blocks upstream
//   acceptance but the held entry may still drain.
//
//   Optional macro PIPE_STAGE_SKID_EN adds a skid entry so in_ready no longer
//   depends combinationally on out_ready. Without it the stage holds at most
//   one entry and in_ready = ~stall & (~out_valid | out_ready).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   kill all held entries
//   stall                   hazard-unit freeze of upstream acceptance
//   in_valid/in_ready       upstream handshake
//   in_ctrl, in_data        upstream payload
//   out_valid/out_ready     downstream handshake
//   out_ctrl, out_data      registered payload (ctrl is zero whenever invalid)
//   occupancy               registered number of valid entries
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W             = 24,
  parameter int unsigned DATA_W             = 160,
  parameter bit          ZERO_DATA_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_state_e      state_q;
  logic [1:0]        occ_q;
  logic              accept;
  logic              pop;
  logic              main_clr;
  logic              main_load;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_clr;
  logic              skid_load;

  // Ready comes only from registered state plus the stall input.
  assign in_ready = ~skid_valid & ~stall;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the case leaves it unassigned (which would infer a latch).
    main_clr    = flush;
    main_load   = 1'b0;
    skid_clr    = flush;
    skid_load   = 1'b0;
    main_ctrl_d = in_ctrl;
    main_data_d = in_data;
    if (!flush) begin
      unique case (state_q)
        EMPTY: main_load = accept;
        FULL: begin
          if (pop) begin
            main_load = accept;
            main_clr  = ~accept;
          end else begin
            skid_load = accept;
          end
        end
        SKID: begin
          // in_ready is low here, so the skid entry is the only source.
          if (pop) begin
            main_load   = 1'b1;
            main_ctrl_d = skid_ctrl;
            main_data_d = skid_data;
            skid_clr    = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_skid_entry #(
    .CTRL_W    (CTRL_W),
    .DATA_W    (DATA_W),
    .ZERO_DATA (ZERO_DATA_ON_FLUSH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (skid_clr),
    .load_i  (skid_load),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );
`else
  assign in_ready = ~stall & (~out_valid | out_ready);

  always_comb begin
    main_clr    = flush;
    main_load   = 1'b0;
    main_ctrl_d = in_ctrl;
    main_data_d = in_data;
    if (!flush) begin
      unique case (state_q)
        EMPTY: main_load = accept;
        FULL: begin
          // Popping without a replacement leaves a bubble.
          if (pop) begin
            main_load = accept;
            main_clr  = ~accept;
          end
        end
        default: main_clr = 1'b1;
      endcase
    end
  end
`endif

  pipe_skid_entry #(
    .CTRL_W    (CTRL_W),
    .DATA_W    (DATA_W),
    .ZERO_DATA (ZERO_DATA_ON_FLUSH)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (main_clr),
    .load_i  (main_load),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .valid_o (out_valid),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data)
  );

  // Occupancy state machine; occupancy is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      occ_q   <= 2'd0;
    end else if (flush) begin
      state_q <= EMPTY;
      occ_q   <= 2'd0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
            occ_q   <= 2'd1;
          end
        end
        FULL: begin
          if (pop && !accept) begin
            state_q <= EMPTY;
            occ_q   <= 2'd0;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (!pop && accept) begin
            state_q <= SKID;
            occ_q   <= 2'd2;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (pop) begin
            state_q <= FULL;
            occ_q   <= 2'd1;
          end
        end
`endif
        default: begin
          state_q <= EMPTY;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

  assign occupancy = occ_q;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Table-driven bench for pipe_stage_reg. Each vector gives the inputs for one
//   cycle plus the occupancy expected after the clock edge. A queue model of
//   the stage contents (pushed on accept, popped on consume, emptied on flush)
//   supplies the expected in_ready/out_valid/out_ctrl/out_data. Reset and the
//   ZERO_DATA_ON_FLUSH=0 hold behaviour are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int CW = 24;
  localparam int DW = 160;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID_MODE = 1'b1;
`else
  localparam bit SKID_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  logic          nz_in_ready, nz_out_valid;
  logic [CW-1:0] nz_out_ctrl;
  logic [DW-1:0] nz_out_data;
  logic [1:0]    nz_occupancy;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA_ON_FLUSH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA_ON_FLUSH(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(nz_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(nz_out_valid), .out_ready(out_ready), .out_ctrl(nz_out_ctrl), .out_data(nz_out_data),
    .occupancy(nz_occupancy)
  );

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct {
    logic       iv;
    logic       st;
    logic       fl;
    logic       ordy;
    logic [7:0] tag;
    logic [1:0] exp_occ;
  } vec_t;

  entry_t sb[$];
  vec_t   vecs[$];
  int     total = 0;
  int     bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_ctrl(input logic [7:0] tag);
    return 24'h800000 | CW'(tag);
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [7:0] tag);
    return (DW'(tag) << 128) | DW'(tag);
  endfunction

  function automatic void add(input logic iv, input logic st, input logic fl,
                              input logic ordy, input logic [7:0] tag, input logic [1:0] occ);
    vec_t v;
    v.iv = iv; v.st = st; v.fl = fl; v.ordy = ordy; v.tag = tag; v.exp_occ = occ;
    vecs.push_back(v);
  endfunction

  // One cycle: drive, check outputs and in_ready at the negedge against the
  // queue model, advance the model at the edge, then check occupancy.
  task automatic apply(input vec_t v, input int idx);
    logic   exp_rdy;
    logic   acc;
    logic   pp;
    entry_t e;
    in_valid  = v.iv;
    stall     = v.st;
    flush     = v.fl;
    out_ready = v.ordy;
    in_ctrl   = mk_ctrl(v.tag);
    in_data   = mk_data(v.tag);
    @(negedge clk);
    if (SKID_MODE) exp_rdy = !v.st && (sb.size() < 2);
    else           exp_rdy = !v.st && (sb.size() == 0 || v.ordy);
    check($sformatf("in_ready[%0d]", idx), DW'(in_ready), DW'(exp_rdy));
    check($sformatf("out_valid[%0d]", idx), DW'(out_valid), DW'(sb.size() > 0));
    check($sformatf("out_ctrl[%0d]", idx), DW'(out_ctrl),
          (sb.size() > 0) ? DW'(sb[0].ctrl) : '0);
    check($sformatf("out_data[%0d]", idx), out_data,
          (sb.size() > 0) ? sb[0].data : '0);
    acc = v.iv && exp_rdy;
    pp  = (sb.size() > 0) && v.ordy;
    @(posedge clk);
    #1;
    if (v.fl) begin
      sb.delete();
    end else begin
      if (pp) void'(sb.pop_front());
      if (acc) begin
        e.ctrl = mk_ctrl(v.tag);
        e.data = mk_data(v.tag);
        sb.push_back(e);
      end
    end
    check($sformatf("occupancy[%0d]", idx), DW'(occupancy), DW'(v.exp_occ));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- vector table ----------------
    // Streaming 1..8, no bubbles, then drain.
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 1, 8'(i), 2'd1);
    add(0, 0, 0, 1, 8'h00, 2'd0);
    // Backpressure: 5 held, 6 offered.
    add(1, 0, 0, 1, 8'h05, 2'd1);
    if (SKID_MODE) begin
      add(1, 0, 0, 0, 8'h06, 2'd2);   // 6 lands in the skid entry
      add(0, 0, 0, 0, 8'h00, 2'd2);
      add(0, 0, 0, 0, 8'h00, 2'd2);
      add(0, 0, 0, 1, 8'h00, 2'd1);   // 5 pops, 6 moves to main
      add(0, 0, 0, 1, 8'h00, 2'd0);   // 6 pops
    end else begin
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 8'h06, 2'd1);
      add(1, 0, 0, 1, 8'h06, 2'd1);   // 5 pops, 6 accepted
      add(0, 0, 0, 1, 8'h00, 2'd0);   // 6 pops
    end
    // Stall: 7 drains, new entry refused.
    add(1, 0, 0, 0, 8'h07, 2'd1);
    add(1, 1, 0, 1, 8'h09, 2'd0);
    add(1, 1, 0, 1, 8'h09, 2'd0);
    add(0, 0, 0, 1, 8'h00, 2'd0);
    // Flush beats stall with the stage as full as it gets.
    add(1, 0, 0, 0, 8'h11, 2'd1);
    add(1, 0, 0, 0, 8'h12, SKID_MODE ? 2'd2 : 2'd1);
    add(1, 1, 1, 0, 8'h13, 2'd0);
    add(0, 0, 0, 1, 8'h00, 2'd0);
    // Flush on an empty stage with in_ready high: entry discarded.
    add(1, 0, 1, 1, 8'h14, 2'd0);
    add(0, 0, 0, 1, 8'h00, 2'd0);
    // Flush while popping and accepting.
    add(1, 0, 0, 0, 8'h21, 2'd1);
    add(1, 0, 1, 1, 8'h22, 2'd0);
    add(0, 0, 0, 1, 8'h00, 2'd0);

    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_occupancy", DW'(occupancy), '0);
    rst_n = 1'b1;

    // Reset mid-stream: asynchronous clear of a loaded entry.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_ctrl   = 24'h0000A5;
    in_data   = DW'(16'h1234);
    @(posedge clk);
    #1;
    check("load_out_data", out_data, DW'(16'h1234));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("arst_out_valid", DW'(out_valid), '0);
    check("arst_out_ctrl", DW'(out_ctrl), '0);
    check("arst_out_data", out_data, '0);
    check("arst_occupancy", DW'(occupancy), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // ---------------- ZERO_DATA_ON_FLUSH=0 holds data ----------------
    in_valid  = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = 24'h8000AA;
    in_data   = DW'(16'hDEAD);
    @(posedge clk);
    #1;
    check("nz_loaded_data", nz_out_data, DW'(16'hDEAD));
    in_valid = 1'b0;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("nz_flush_valid", DW'(nz_out_valid), '0);
    check("nz_flush_ctrl", DW'(nz_out_ctrl), '0);
    check("nz_flush_data", nz_out_data, DW'(16'hDEAD));
    check("nz_flush_occ", DW'(nz_occupancy), '0);
    check("z_flush_data", out_data, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register: successor to the fixed per-stage latches (IF/OF, OF/ALU, ALU/MA, MA/RW).
- Carries a control vector and a data vector between two stages using valid/ready handshaking.
- Supports hazard-unit stall and branch flush; flush takes priority over stall.
- An optional skid entry makes the upstream ready a registered signal.

Parameters:
- CTRL_W, 24, width of control payload (isWb, isLd, isSt, branch flags, aluSignals, rd…); always zeroed on flush.
- DATA_W, 160, width of data payload (pc, inst, immx, op1, op2, B…).
- ZERO_DATA_ON_FLUSH, 1, 1: data zeroed on flush/bubble; 0: data held (saves power).

Ports:
- clk, input, 1, stage clock.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, kill all held entries (branch taken).
- stall, input, 1, hazard-unit freeze of upstream acceptance.
- in_valid, input, 1, upstream entry valid.
- in_ready, output, 1, stage can accept this cycle.
- in_ctrl, input, CTRL_W, upstream control.
- in_data, input, DATA_W, upstream data.
- out_valid, output, 1, held entry valid.
- out_ready, input, 1, downstream consumes entry.
- out_ctrl, output, CTRL_W, registered control.
- out_data, output, DATA_W, registered data.
- occupancy, output, 2, entries held (0..1, or 0..2 with skid).

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_ctrl=0, out_data=0, skid cleared, occupancy=0, state EMPTY. Must hold mid-transfer; the first accept is possible on the cycle after deassertion.
- accept = in_valid & in_ready. pop = out_valid & out_ready. Latency in→out is exactly 1 cycle.
- Base mode (no skid):
  - in_ready = ~stall & (~out_valid | out_ready), combinational.
  - States: EMPTY, FULL.
  - EMPTY: accept → FULL.
  - FULL: pop & accept → FULL with new entry; pop & ~accept → EMPTY (bubble); ~pop → hold.
- Flush: highest priority over stall, accept and pop.
  - Next cycle out_valid=0, out_ctrl=0, out_data=0 (if ZERO_DATA_ON_FLUSH), skid cleared, state EMPTY.
  - An entry presented on the flush cycle is discarded; in_ready may still be high.
- Stall: forces in_ready=0. Held entry may still pop; after a pop under stall the stage goes EMPTY.
- Bubble: out_ctrl is zeroed whenever out_valid=0, so downstream sees isWb=0 and isSt=0.
- Simultaneous flush & stall: flush wins; the stage empties.
- occupancy = count of valid entries, registered.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- When defined:
  - Adds one skid entry; in_ready = ~skid_valid_q & ~stall, with no combinational path from out_ready.
  - States: EMPTY, FULL, SKID.
  - FULL & accept & ~pop → SKID (entry stored in skid).
  - SKID & pop → FULL (skid moves to main; in_ready was 0 that cycle).
  - SKID & ~pop → hold.
  - occupancy reaches 2.
- When undefined: base mode only; skid registers absent; occupancy never exceeds 1.

Decomposition:
- Shared package pipe_pkg holds:
  - per-stage CTRL_W/DATA_W constants;
  - packed struct typedefs for each stage's control and data vectors;
  - state enum {EMPTY, FULL, SKID}.
- One natural sub-module, pipe_skid_entry: a single valid+payload register with load and clear, instanced for main and skid.

Test Plan:
- Reset mid-stream: load ctrl=0x00_00A5, data=0x…1234, assert rst_n=0 for 1 cycle → out_valid=0, out_ctrl=0, out_data=0, occupancy=0 immediately.
- Streaming: in_valid=1 with 8 consecutive entries 1..8, out_ready=1 → out_data=1..8 on consecutive cycles, one cycle after input, no bubbles.
- Backpressure: out_ready=0 for 3 cycles with entry 5 held, in_valid=1 entry 6:
  - base mode: in_ready=0 and out_data stays 5;
  - skid mode: entry 6 accepted into skid, occupancy=2, in_ready=0.
  - On out_ready=1 → 5 then 6.
- Stall: stall=1, out_ready=1, entry 7 held → 7 pops, stage EMPTY, out_ctrl=0, in_ready=0 during stall.
- Flush beats stall: flush=1 & stall=1 with occupancy=2 → next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; entry presented on the flush cycle never appears.
- Flush with ZERO_DATA_ON_FLUSH=0: data 0xDEAD held, out_ctrl=0, out_valid=0.
